// File: rtl/mbx_ombx_reader.sv
// Outbound mailbox read sequencer: streams the outbound object out of SRAM one
// word at a time and presents each word to the system interface until consumed.
module mbx_ombx_reader #(
  parameter int AddrWidth = 32,
  parameter int SizeWidth = 11
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 mbx_read_i,
  input  logic                 abort_i,
  input  logic [AddrWidth-1:0] range_base_i,
  input  logic [AddrWidth-1:0] range_limit_i,
  input  logic [SizeWidth-1:0] object_size_i,
  input  logic                 sysif_read_i,
  output logic                 sram_req_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  input  logic                 sram_gnt_i,
  input  logic                 sram_rvalid_i,
  input  logic [31:0]          sram_rdata_i,
  output logic [31:0]          rdata_o,
  output logic                 rdata_valid_o,
  output logic                 sys_read_all_o,
  output logic                 read_error_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_FLUSH
  } state_e;

  localparam logic [AddrWidth:0]   WordStep = 4;
  localparam logic [SizeWidth-1:0] OneWord  = 1;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [SizeWidth-1:0]   remaining_q, remaining_d;
  logic                   discard_q, discard_d;
  logic                   start_pending_q, start_pending_d;
  logic                   mbx_read_q;
  logic [31:0]            rdata_q, rdata_d;
  logic                   rdata_valid_q, rdata_valid_d;
  logic                   read_all_q, read_all_d;
  logic                   read_error_q, read_error_d;

  logic                   read_rise;
  logic                   read_fall;
  logic                   abort;
  logic [AddrWidth:0]     addr_inc;
  logic                   next_out_of_range;
  logic                   last_word;

  assign read_rise = mbx_read_i & ~mbx_read_q;
  assign read_fall = ~mbx_read_i & mbx_read_q;
  assign abort     = abort_i | read_fall;

  // The extra top bit is the carry-out, so a wrap past all-ones is out of range
  assign addr_inc          = {1'b0, addr_q} + WordStep;
  assign next_out_of_range = addr_inc[AddrWidth] | (addr_inc[AddrWidth-1:0] > range_limit_i);
  assign last_word         = remaining_q <= OneWord;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      discard_q       <= 1'b0;
      start_pending_q <= 1'b0;
      mbx_read_q      <= 1'b0;
      rdata_q         <= '0;
      rdata_valid_q   <= 1'b0;
      read_all_q      <= 1'b0;
      read_error_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remaining_q     <= remaining_d;
      discard_q       <= discard_d;
      start_pending_q <= start_pending_d;
      mbx_read_q      <= mbx_read_i;
      rdata_q         <= rdata_d;
      rdata_valid_q   <= rdata_valid_d;
      read_all_q      <= read_all_d;
      read_error_q    <= read_error_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    remaining_d     = remaining_q;
    discard_d       = discard_q;
    start_pending_d = start_pending_q;
    rdata_d         = rdata_q;
    rdata_valid_d   = rdata_valid_q;
    read_all_d      = 1'b0;
    read_error_d    = 1'b0;

    if (abort) begin
      rdata_d         = '0;
      rdata_valid_d   = 1'b0;
      remaining_d     = '0;
      start_pending_d = 1'b0;
      // A granted request still owes a response; wait for it before idling
      case (state_q)
        ST_REQ: begin
          if (sram_gnt_i) begin
            state_d   = ST_FLUSH;
            discard_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WAIT, ST_FLUSH: begin
          if (sram_rvalid_i) begin
            state_d   = ST_IDLE;
            discard_d = 1'b0;
          end else begin
            state_d   = ST_FLUSH;
            discard_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (read_rise || start_pending_q) begin
            start_pending_d = 1'b0;
            addr_d          = range_base_i;
            remaining_d     = object_size_i;
            if (object_size_i == '0) begin
              state_d       = ST_HOLD;
              rdata_d       = '0;
              rdata_valid_d = 1'b0;
            end else if (range_base_i > range_limit_i) begin
              read_error_d = 1'b1;
            end else begin
              state_d = ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (sysif_read_i) read_error_d = 1'b1;
          if (sram_gnt_i) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (sysif_read_i) read_error_d = 1'b1;
          if (sram_rvalid_i) begin
            rdata_d       = sram_rdata_i;
            rdata_valid_d = 1'b1;
            state_d       = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (sysif_read_i) begin
            rdata_d       = '0;
            rdata_valid_d = 1'b0;
            if (last_word) begin
              read_all_d = 1'b1;
              state_d    = ST_IDLE;
            end else begin
              remaining_d = remaining_q - OneWord;
              addr_d      = addr_inc[AddrWidth-1:0];
              if (next_out_of_range) begin
                read_error_d = 1'b1;
                state_d      = ST_IDLE;
              end else begin
                state_d = ST_REQ;
              end
            end
          end
        end
        ST_FLUSH: begin
          if (read_rise) start_pending_d = 1'b1;
          if (sram_rvalid_i && discard_q) begin
            discard_d = 1'b0;
            state_d   = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    sram_req_o  = 1'b0;
    sram_addr_o = '0;
    if (state_q == ST_REQ) begin
      sram_req_o  = 1'b1;
      sram_addr_o = addr_q;
    end
  end

  assign rdata_o        = rdata_q;
  assign rdata_valid_o  = rdata_valid_q;
  assign sys_read_all_o = read_all_q;
  assign read_error_o   = read_error_q;

endmodule

// File: tb/tb_mbx_ombx_reader.sv
// Randomized bench for mbx_ombx_reader: an SRAM responder plus a message-level
// reference model that derives fetch addresses and the end outcome from base/limit/size.
module tb_mbx_ombx_reader;

  localparam int AW = 32;
  localparam int SW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          mbx_read;
  logic          abort;
  logic [AW-1:0] range_base;
  logic [AW-1:0] range_limit;
  logic [SW-1:0] object_size;
  logic          sysif_read;
  logic          sram_req;
  logic [AW-1:0] sram_addr;
  logic          sram_gnt = 1'b0;
  logic          sram_rvalid = 1'b0;
  logic [31:0]   sram_rdata = '0;
  logic [31:0]   rdata;
  logic          rdata_valid;
  logic          sys_read_all;
  logic          read_error;

  mbx_ombx_reader #(.AddrWidth(AW), .SizeWidth(SW)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .mbx_read_i    (mbx_read),
    .abort_i       (abort),
    .range_base_i  (range_base),
    .range_limit_i (range_limit),
    .object_size_i (object_size),
    .sysif_read_i  (sysif_read),
    .sram_req_o    (sram_req),
    .sram_addr_o   (sram_addr),
    .sram_gnt_i    (sram_gnt),
    .sram_rvalid_i (sram_rvalid),
    .sram_rdata_i  (sram_rdata),
    .rdata_o       (rdata),
    .rdata_valid_o (rdata_valid),
    .sys_read_all_o(sys_read_all),
    .read_error_o  (read_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          gnt_delay = 0;
  int          rsp_lat = 1;
  int          wait_cnt = 0;
  int          resp_cnt = 0;
  logic [31:0] resp_data = '0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] req_log [$];
  int          stable_errs = 0;
  int          overlap_errs = 0;
  int          bad_seen = 0;
  logic        prev_req = 1'b0;
  logic [31:0] prev_addr = '0;

  // SRAM responder and port monitor; drives gnt/rvalid on the falling edge
  always @(negedge clk) begin
    if (!rst && prev_req && !sram_gnt && (!sram_req || sram_addr != prev_addr)) stable_errs++;
    prev_req  = sram_req;
    prev_addr = sram_addr;
    if (rdata === 32'hDEADBEEF) bad_seen++;
    sram_rvalid = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        sram_rvalid = 1'b1;
        sram_rdata  = resp_data;
      end
    end
    sram_gnt = 1'b0;
    if (sram_req === 1'b1) begin
      if (wait_cnt >= gnt_delay) begin
        if (resp_cnt > 0) overlap_errs++;
        sram_gnt  = 1'b1;
        wait_cnt  = 0;
        req_log.push_back(sram_addr);
        resp_cnt  = rsp_lat;
        resp_data = mem.exists(sram_addr) ? mem[sram_addr] : 32'h0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseRead();
    sysif_read = 1'b1;
    step();
    sysif_read = 1'b0;
  endtask

  task automatic waitValid(input string tag, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (rdata_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // One complete message: reference model first, then drive and compare
  task automatic applyStimulus(input logic [31:0] base, input logic [31:0] limit,
                               input int size, input bit pattern);
    logic [31:0] exp_addr [$];
    logic [63:0] a;
    bit          start_err;
    bit          end_err;
    bit          ok;
    bit          last;

    start_err = (size != 0) && (base > limit);
    end_err   = 1'b0;
    if (!start_err) begin
      for (int i = 0; i < size; i++) begin
        a = {32'h0, base} + 64'(4 * i);
        if (a > 64'hFFFF_FFFF || a[31:0] > limit) begin
          end_err = 1'b1;
          break;
        end
        exp_addr.push_back(a[31:0]);
      end
    end

    mem.delete();
    foreach (exp_addr[i]) mem[exp_addr[i]] = pattern ? 32'hAAAA0001 + 32'(i) : $urandom();
    req_log.delete();
    stable_errs  = 0;
    overlap_errs = 0;

    range_base  = base;
    range_limit = limit;
    object_size = SW'(size);
    mbx_read    = 1'b1;
    step();

    if (start_err) begin
      checkOutput("start_range_error", {31'd0, read_error}, 32'd1);
      repeat (4) step();
      checkOutput("start_no_req", req_log.size(), 32'd0);
    end else if (size == 0) begin
      step();
      checkOutput("zero_valid", {31'd0, rdata_valid}, 32'd0);
      checkOutput("zero_rdata", rdata, 32'd0);
      pulseRead();
      checkOutput("zero_read_all", {31'd0, sys_read_all}, 32'd1);
      checkOutput("zero_no_req", req_log.size(), 32'd0);
    end else begin
      foreach (exp_addr[i]) begin
        waitValid("fetch", ok);
        if (!ok) break;
        checkOutput("fetch_addr", (req_log.size() > 0) ? req_log[$] : 32'hFFFF_FFFF, exp_addr[i]);
        checkOutput("fetch_count", req_log.size(), 32'(i + 1));
        checkOutput("fetch_data", rdata, mem[exp_addr[i]]);
        repeat ($urandom_range(0, 2)) step();
        pulseRead();
        last = (i == exp_addr.size() - 1);
        checkOutput("read_all", {31'd0, sys_read_all}, {31'd0, last && !end_err});
        checkOutput("read_error", {31'd0, read_error}, {31'd0, last && end_err});
        checkOutput("valid_drop", {31'd0, rdata_valid}, 32'd0);
      end
      repeat (3) step();
      checkOutput("total_reqs", req_log.size(), exp_addr.size());
    end
    checkOutput("addr_stable", stable_errs, 32'd0);
    checkOutput("one_outstanding", overlap_errs, 32'd0);
    mbx_read = 1'b0;
    repeat (2) step();
  endtask

  task automatic abortScenario();
    bit ok;
    mem.delete();
    req_log.delete();
    mem[32'h400] = 32'hDEADBEEF;
    rsp_lat      = 4;
    gnt_delay    = 0;
    bad_seen     = 0;
    overlap_errs = 0;
    range_base   = 32'h400;
    range_limit  = 32'h4FC;
    object_size  = SW'(1);
    mbx_read     = 1'b1;
    step();
    step();
    checkOutput("abort_wait_no_req", {31'd0, sram_req}, 32'd0);
    checkOutput("abort_granted", req_log.size(), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    checkOutput("abort_valid", {31'd0, rdata_valid}, 32'd0);
    mbx_read     = 1'b0;
    rsp_lat      = 1;
    mem[32'h400] = 32'h12345678;
    step();
    mbx_read = 1'b1;
    step();
    waitValid("restart", ok);
    checkOutput("restart_data", rdata, 32'h12345678);
    checkOutput("no_deadbeef", bad_seen, 32'd0);
    checkOutput("restart_reqs", req_log.size(), 32'd2);
    checkOutput("abort_one_outstanding", overlap_errs, 32'd0);
    pulseRead();
    checkOutput("restart_read_all", {31'd0, sys_read_all}, 32'd1);
    mbx_read = 1'b0;
    repeat (2) step();
  endtask

  task automatic earlyReadReset();
    bit          ok;
    logic [31:0] word;
    mem.delete();
    req_log.delete();
    word         = $urandom();
    mem[32'h600] = word;
    gnt_delay    = 5;
    rsp_lat      = 1;
    range_base   = 32'h600;
    range_limit  = 32'h6FC;
    object_size  = SW'(2);
    mbx_read     = 1'b1;
    step();
    checkOutput("early_req", {31'd0, sram_req}, 32'd1);
    pulseRead();
    checkOutput("early_read_error", {31'd0, read_error}, 32'd1);
    checkOutput("early_still_req", {31'd0, sram_req}, 32'd1);
    checkOutput("early_addr", sram_addr, 32'h600);
    checkOutput("early_rdata", rdata, 32'd0);
    checkOutput("early_no_read_all", {31'd0, sys_read_all}, 32'd0);
    waitValid("early_fetch", ok);
    checkOutput("early_data", rdata, word);
    step();
    #3 rst = 1'b1;
    #1;
    checkOutput("rst_valid", {31'd0, rdata_valid}, 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_req", {31'd0, sram_req}, 32'd0);
    checkOutput("rst_addr", sram_addr, 32'd0);
    mbx_read = 1'b0;
    step();
    rst = 1'b0;
    step();
    checkOutput("post_rst_req", {31'd0, sram_req}, 32'd0);
    gnt_delay = 0;
  endtask

  initial begin
    logic [31:0] rbase;
    logic [31:0] rlimit;
    rst         = 1'b1;
    mbx_read    = 1'b0;
    abort       = 1'b0;
    range_base  = '0;
    range_limit = '0;
    object_size = '0;
    sysif_read  = 1'b0;
    #3;
    checkOutput("reset_req", {31'd0, sram_req}, 32'd0);
    checkOutput("reset_addr", sram_addr, 32'd0);
    checkOutput("reset_rdata", rdata, 32'd0);
    checkOutput("reset_valid", {31'd0, rdata_valid}, 32'd0);
    checkOutput("reset_read_all", {31'd0, sys_read_all}, 32'd0);
    checkOutput("reset_error", {31'd0, read_error}, 32'd0);
    step();
    rst = 1'b0;
    step();

    $display("[TB] normal three-word message");
    applyStimulus(32'h100, 32'h1FC, 3, 1'b1);
    $display("[TB] zero-size object");
    applyStimulus(32'h200, 32'h2FC, 0, 1'b0);
    $display("[TB] range overflow");
    applyStimulus(32'h1F8, 32'h1FC, 4, 1'b1);
    $display("[TB] address wrap past all-ones");
    applyStimulus(32'hFFFF_FFF8, 32'hFFFF_FFFC, 4, 1'b0);
    $display("[TB] base above limit at start");
    applyStimulus(32'h500, 32'h4FC, 2, 1'b0);
    $display("[TB] back-pressure");
    gnt_delay = 5;
    applyStimulus(32'h300, 32'h3FC, 2, 1'b0);
    gnt_delay = 0;
    $display("[TB] abort with response outstanding");
    abortScenario();
    $display("[TB] early read and reset");
    earlyReadReset();

    $display("[TB] randomized messages");
    for (int n = 0; n < 24; n++) begin
      gnt_delay = $urandom_range(0, 3);
      rsp_lat   = $urandom_range(1, 3);
      rbase     = $urandom();
      rbase[1:0] = 2'b00;
      if ($urandom_range(0, 5) == 0) rlimit = rbase - 32'd4;
      else rlimit = rbase + 32'(4 * $urandom_range(0, 6));
      applyStimulus(rbase, rlimit, $urandom_range(0, 6), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
